break_controller: RTL

- Generates the processor break request (oBreak) consumed by the clock interface's break input.
- Freezes auto-clock mode when the processor PC matches a programmed breakpoint, or when a programmed instruction-step count expires.
- Runs on the 50 MHz board clock and watches the processor clock as a data signal through a synchronizer.
- Configured through a small write port driven by the memory-mapped debug bus.

---
 rtl/break_controller.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/break_controller.sv
// Breakpoint / single-step break generator for the processor clock interface.
// Optional saturating break counter enabled with `define BREAK_HITCNT_EN.
module break_controller #(
    parameter  int NUM_BP    = 4,
    parameter  int ADDR_W    = 32,
    parameter  int CNT_W     = 16,
    parameter  int PULSE_LEN = 4,
    localparam int IDX_W     = $clog2(NUM_BP + 1)
) (
    input  logic              iCLK_50,
    input  logic              iRST_n,
    input  logic              iCPU_CLK,
    input  logic [ADDR_W-1:0] iPC,
    input  logic              iCfgWr,
    input  logic [3:0]        iCfgAddr,
    input  logic [31:0]       iCfgData,
    input  logic              iResume,
    output logic              oBreak,
    output logic              oHalted,
    output logic [IDX_W-1:0]  oHitIdx,
    output logic [CNT_W-1:0]  oStepsLeft,
    output logic [15:0]       oHitCount
);

    localparam int PCNT_W = $clog2(PULSE_LEN + 1);

    typedef enum logic [2:0] {IDLE, ARMED, PULSE, HALTED, SKIP} state_t;

    state_t              state;
    logic [2:0]          cpu_sync;
    logic [ADDR_W-1:0]   bp_addr [NUM_BP];
    logic [NUM_BP-1:0]   ctrl_en;
    logic                step_en;
    logic [PCNT_W-1:0]   pulse_cnt;
    logic                resume_d;

    logic                ev;
    logic                hit_any;
    logic [IDX_W-1:0]    hit_idx;
    logic                expire;
    logic                armed_any;

    // cpu_sync[1:0] is the synchronizer, cpu_sync[2] the edge-detect delay
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) cpu_sync <= '0;
        else         cpu_sync <= {cpu_sync[1:0], iCPU_CLK};
    end

    assign ev        = cpu_sync[1] & ~cpu_sync[2];
    assign armed_any = (|ctrl_en) | step_en;
    assign expire    = ev & step_en & (oStepsLeft == CNT_W'(1));

    // Scan high to low so the lowest matching comparator is the one kept
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (ev && ctrl_en[i] && (iPC == bp_addr[i])) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
            ctrl_en <= '0;
            step_en <= 1'b0;
        end else if (iCfgWr) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (iCfgAddr == 4'(i)) bp_addr[i] <= iCfgData[ADDR_W-1:0];
            end
            if (iCfgAddr == 4'd8) begin
                ctrl_en <= iCfgData[NUM_BP-1:0];
                step_en <= iCfgData[8];
            end
        end
    end

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= IDLE;
            oBreak     <= 1'b0;
            oHalted    <= 1'b0;
            oHitIdx    <= '0;
            oStepsLeft <= '0;
            pulse_cnt  <= '0;
            resume_d   <= 1'b0;
        end else begin
            resume_d <= iResume;
            if (state == ARMED && step_en && oStepsLeft != '0 && ev)
                oStepsLeft <= oStepsLeft - CNT_W'(1);
            // A debug-bus load overrides a same-cycle decrement
            if (iCfgWr && iCfgAddr == 4'd9)
                oStepsLeft <= iCfgData[CNT_W-1:0];

            case (state)
                IDLE: begin
                    if (armed_any) state <= ARMED;
                end
                ARMED: begin
                    if (hit_any || expire) begin
                        state     <= PULSE;
                        oBreak    <= 1'b1;
                        pulse_cnt <= PCNT_W'(PULSE_LEN - 1);
                        oHitIdx   <= hit_any ? hit_idx : IDX_W'(NUM_BP);
                    end else if (!armed_any) begin
                        state <= IDLE;
                    end
                end
                PULSE: begin
                    if (pulse_cnt == '0) begin
                        oBreak  <= 1'b0;
                        oHalted <= 1'b1;
                        state   <= HALTED;
                    end else begin
                        pulse_cnt <= pulse_cnt - PCNT_W'(1);
                    end
                end
                HALTED: begin
                    if (iResume && !resume_d) begin
                        oHalted <= 1'b0;
                        state   <= SKIP;
                    end
                end
                SKIP: begin
                    // Swallow the first edge so a breakpoint at the resume PC does not refire
                    if (ev) state <= armed_any ? ARMED : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BREAK_HITCNT_EN
    logic brk_start;
    assign brk_start = (state == ARMED) && (hit_any || expire);

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n)
            oHitCount <= '0;
        else if (iCfgWr && iCfgAddr == 4'd10)
            oHitCount <= '0;
        else if (brk_start && oHitCount != 16'hFFFF)
            oHitCount <= oHitCount + 16'd1;
    end
`else
    assign oHitCount = '0;
`endif

endmodule
